// File: rtl/n64_bus_arbiter.sv
// Round-robin arbiter sharing the SDRAM/flash bus between PI (0), CPU (1) and USB/DMA (2).
// Define N64_BUS_ARB_PI_PRIORITY_EN to make PI win every arbitration it takes part in.
module n64_bus_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 26
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_REQ-1:0]        i_request,
  input  logic [NUM_REQ-1:0]        i_write,
  input  logic [4*NUM_REQ-1:0]      i_bank,
  input  logic [ADDR_W*NUM_REQ-1:0] i_address,
  input  logic [32*NUM_REQ-1:0]     i_wdata,
  output logic [NUM_REQ-1:0]        o_busy,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [31:0]               o_rdata,
  output logic                      o_mem_request,
  output logic                      o_mem_write,
  output logic [3:0]                o_mem_bank,
  output logic [ADDR_W-1:0]         o_mem_address,
  output logic [31:0]               o_mem_wdata,
  input  logic                      i_mem_busy,
  input  logic                      i_mem_ack,
  input  logic [31:0]               i_mem_rdata,
  output logic                      o_stray_ack
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck} state_e;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         rr_q, rr_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_write_q, mem_write_d;
  logic [3:0]         mem_bank_q, mem_bank_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               stray_q, stray_d;

  logic [1:0]         win;
  logic               found;

  always_comb begin
    int cand;
    win   = '0;
    found = 1'b0;
    cand  = 0;
`ifdef N64_BUS_ARB_PI_PRIORITY_EN
    // PI pre-empts; the pointer only alternates between requesters 1 and 2.
    if (i_request[0]) begin
      win   = 2'd0;
      found = 1'b1;
    end else if (rr_q == 2'd2) begin
      if (i_request[2]) begin
        win   = 2'd2;
        found = 1'b1;
      end else if (i_request[1]) begin
        win   = 2'd1;
        found = 1'b1;
      end
    end else begin
      if (i_request[1]) begin
        win   = 2'd1;
        found = 1'b1;
      end else if (i_request[2]) begin
        win   = 2'd2;
        found = 1'b1;
      end
    end
`else
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = (int'(rr_q) + i) % int'(NUM_REQ);
      if (!found && i_request[cand]) begin
        win   = cand[1:0];
        found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_bank_d  = mem_bank_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    stray_d     = stray_q;
    o_busy      = '1;
    o_ack       = '0;
    o_rdata     = '0;

    unique case (state_q)
      StIdle: begin
        if (i_mem_ack) stray_d = 1'b1;
        if (found) begin
          state_d     = StIssue;
          grant_d     = win;
          mem_req_d   = 1'b1;
          mem_write_d = i_write[win];
          mem_bank_d  = i_bank[win*4 +: 4];
          mem_addr_d  = i_address[win*ADDR_W +: ADDR_W];
          mem_wdata_d = i_wdata[win*32 +: 32];
`ifdef N64_BUS_ARB_PI_PRIORITY_EN
          if (win != 2'd0) rr_d = (win == 2'd1) ? 2'd2 : 2'd1;
`else
          rr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
`endif
        end
      end
      StIssue: begin
        if (i_mem_ack) stray_d = 1'b1;
        if (!i_mem_busy) begin
          o_busy[grant_q] = 1'b0;
          state_d         = StWaitAck;
          mem_req_d       = 1'b0;
          mem_write_d     = 1'b0;
        end
      end
      StWaitAck: begin
        if (i_mem_ack) begin
          o_ack[grant_q] = 1'b1;
          o_rdata        = i_mem_rdata;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_bank_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      stray_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_bank_q  <= mem_bank_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      stray_q     <= stray_d;
    end
  end

  assign o_mem_request = mem_req_q;
  assign o_mem_write   = mem_write_q;
  assign o_mem_bank    = mem_bank_q;
  assign o_mem_address = mem_addr_q;
  assign o_mem_wdata   = mem_wdata_q;
  assign o_stray_ack   = stray_q;

endmodule
